// File: rtl/chess_stream_pkg.sv
// chess_stream_pkg
//   Shared definitions for the move-stream path: default widths of a
//   serialized move word and of the serializer move counter, the buffer FSM
//   state encoding, and the width of one buffered {last, data} entry.
package chess_stream_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_CNT_W  = 4;

  // One FIFO entry is the data word plus its end-of-frame flag.
  localparam int PKG_ENTRY_W = PKG_DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } buf_state_t;

  function automatic int entry_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock show-ahead FIFO. Binary read/write pointers carry one extra
//   wrap bit so occupancy is their difference, covering 0..DEPTH without an
//   ambiguous full/empty case. The head entry is read combinationally.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears pointers)
//   push, wdata   write strobe and entry; ignored while full
//   pop           read strobe; ignored while empty
//   rdata         head entry (undefined contents while empty)
//   level         occupancy, 0..DEPTH
//   full, empty   occupancy flags
module sync_fifo
  import chess_stream_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = PKG_ENTRY_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage is not reset; the consumer only sees it through out_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/move_word_buffer.sv
// move_word_buffer
//   Downstream stage of the move serializer. Buffers serialized move words in
//   a FIFO together with an end-of-frame tag, presents them on a valid/ready
//   stream, back-pressures the serializer, and reports per-frame statistics.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input handshake (push = in_valid && in_ready)
//   in_data, in_last           word and end-of-frame flag
//   in_move_count              serializer move counter, taken with the last word
//   out_valid/out_ready        output handshake (pop = out_valid && out_ready)
//   out_data, out_last         head word and its end-of-frame flag
//   frame_done                 pulse in the cycle a last word is popped
//   frame_words, frame_moves   stats of the most recently pushed complete frame
//   frame_count                frames popped since reset (wrapping)
//   level                      FIFO occupancy
//   overflow                   sticky: a word was offered while full
//   busy                       FSM is not idle
module move_word_buffer
  import chess_stream_pkg::*;
#(
  parameter  int DATA_W = PKG_DATA_W,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = PKG_CNT_W,
  parameter  int FCNT_W = 8,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [CNT_W-1:0]  in_move_count,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_words,
  output logic [CNT_W-1:0]  frame_moves,
  output logic [FCNT_W-1:0] frame_count,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic              busy
);

  localparam int EW = entry_width(DATA_W);

  logic              full, empty;
  logic              push, pop;
  logic [EW-1:0]     hd_entry;
  logic              hd_last;
  logic [DATA_W-1:0] hd_data;
  logic              push_last, pop_last;

  logic [LW-1:0]     lasts_q, lasts_nxt;
  logic [LW-1:0]     level_nxt;
  logic [FCNT_W-1:0] wcnt_q, wcnt_inc;
  buf_state_t        state_q;

  // ---------------------------------------------------------------- storage
  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_last, in_data}),
    .pop   (pop),
    .rdata (hd_entry),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign {hd_last, hd_data} = hd_entry;

  // -------------------------------------------------------------- handshake
  // A full FIFO refuses the word even if a pop frees a slot this cycle, so
  // in_ready never depends on out_ready.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;
  assign push_last = push && in_last;
  assign pop_last  = pop && hd_last;

  // Head is masked while empty so stale storage never leaks onto the bus.
  assign out_data   = empty ? '0 : hd_data;
  assign out_last   = !empty && hd_last;
  assign frame_done = pop_last;
  assign busy       = (state_q != ST_IDLE);

  // Number of complete frames sitting in the FIFO. Lets DRAIN stay put when
  // a second frame was fully buffered behind the one being popped.
  assign lasts_nxt = lasts_q + LW'(push_last) - LW'(pop_last);
  assign level_nxt = level + LW'(push) - LW'(pop);

  assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;

  // ------------------------------------------------- counters, flags, stats
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q      <= '0;
      lasts_q     <= '0;
      frame_words <= '0;
      frame_moves <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      lasts_q <= lasts_nxt;
      if (in_valid && full) overflow <= 1'b1;
      if (push_last) begin
        wcnt_q      <= '0;
        frame_words <= wcnt_inc;
        frame_moves <= in_move_count;
      end else if (push) begin
        wcnt_q <= wcnt_inc;
      end
      if (pop_last) frame_count <= frame_count + 1'b1;
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push) state_q <= in_last ? ST_DRAIN : ST_FILL;
        end
        ST_FILL: begin
          if (push_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop_last) begin
            if (lasts_nxt != '0)                 state_q <= ST_DRAIN;
            else if (level_nxt != '0 || push)    state_q <= ST_FILL;
            else                                 state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_word_buffer.sv
module tb_move_word_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 4;
  localparam int FCNT_W = 8;
  localparam int LW     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [CNT_W-1:0]  in_move_count;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_words;
  logic [CNT_W-1:0]  frame_moves;
  logic [FCNT_W-1:0] frame_count;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              busy;

  move_word_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .FCNT_W (FCNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_move_count (in_move_count),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .frame_done    (frame_done),
    .frame_words   (frame_words),
    .frame_moves   (frame_moves),
    .frame_count   (frame_count),
    .level         (level),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_words;
    logic [CNT_W-1:0]  frame_moves;
    logic [FCNT_W-1:0] frame_count;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              busy;
  } snap_t;

  int n_chk  = 0;
  int n_fail = 0;
  snap_t obs, exp;

  // ---------------------------------------------------------- reference model
  // Frame-level view: a queue of {last,data}, a running word count of the
  // open frame, and the statistics as the rules define them.
  logic [DATA_W:0] mq[$];
  bit              m_ovf;
  int              m_cnt, m_fwords, m_moves, m_fcount;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_cnt = 0; m_fwords = 0; m_moves = 0; m_fcount = 0;
  endtask

  function automatic snap_t model_snap(input bit ordy);
    snap_t s;
    bit has = (mq.size() > 0);
    s.in_ready    = (mq.size() < DEPTH);
    s.out_valid   = has;
    s.out_data    = has ? mq[0][DATA_W-1:0] : '0;
    s.out_last    = has ? mq[0][DATA_W] : 1'b0;
    s.frame_done  = has && ordy && mq[0][DATA_W];
    s.frame_words = FCNT_W'(m_fwords);
    s.frame_moves = CNT_W'(m_moves);
    s.frame_count = FCNT_W'(m_fcount);
    s.level       = LW'(mq.size());
    s.overflow    = m_ovf;
    s.busy        = has || (m_cnt != 0);
    return s;
  endfunction

  task automatic model_edge(input bit iv, input logic [DATA_W-1:0] d, input bit il,
                            input logic [CNT_W-1:0] mc, input bit ordy);
    bit is_full = (mq.size() == DEPTH);
    bit pu = iv && !is_full;
    bit po = (mq.size() > 0) && ordy;
    logic [DATA_W:0] e;
    if (iv && is_full) m_ovf = 1;
    if (po) begin
      e = mq.pop_front();
      if (e[DATA_W]) m_fcount = (m_fcount + 1) % 256;
    end
    if (pu) begin
      mq.push_back({il, d});
      if (il) begin
        m_fwords = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        m_moves  = int'(mc);
        m_cnt    = 0;
      end else begin
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
    end
  endtask

  // One clock: drive inputs, snapshot DUT and model on the falling edge,
  // advance the model, return just after the rising edge.
  task automatic cyc(input bit iv, input logic [DATA_W-1:0] d, input bit il,
                     input logic [CNT_W-1:0] mc, input bit ordy);
    in_valid = iv; in_data = d; in_last = il; in_move_count = mc; out_ready = ordy;
    @(negedge clk);
    obs = '{in_ready, out_valid, out_data, out_last, frame_done, frame_words,
            frame_moves, frame_count, level, overflow, busy};
    exp = model_snap(ordy);
    model_edge(iv, d, il, mc, ordy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0; in_move_count = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    snap_t rst_exp;
    do_reset();
    rst_exp = '{1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0};
    cyc(0, '0, 0, '0, 0);
    n_chk++;
    if (obs !== rst_exp) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, rst_exp);
    end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] w [3];
    int done_at;
    w[0] = 32'h0000_0001; w[1] = 32'h0000_0002; w[2] = 32'h8000_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, w[i], (i == 2), 4'd3, 0);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL basic_push: got %h expected %h", obs, exp); end
    end
    cyc(0, '0, 0, '0, 0);
    n_chk++;
    if (obs.level !== 5'd3 || obs.in_ready !== 1'b1 || obs.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: level %0d in_ready %b frame_done %b, need 3 1 0",
                         obs.level, obs.in_ready, obs.frame_done);
    end
    done_at = -1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0, '0, 1);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL basic_pop: got %h expected %h", obs, exp); end
      if (i < 3) begin
        n_chk++;
        if (obs.out_data !== w[i]) begin
          n_fail++; $display("FAIL basic_order: got %h expected %h", obs.out_data, w[i]);
        end
      end
      if (obs.frame_done === 1'b1) done_at = i;
    end
    n_chk++;
    if (done_at != 2 || frame_words !== 8'd3 || frame_moves !== 4'd3 ||
        frame_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_stats: done_at %0d words %0d moves %0d count %0d busy %b, need 2 3 3 1 0",
                         done_at, frame_words, frame_moves, frame_count, busy);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] sent [DEPTH];
    logic [DATA_W-1:0] d;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = $urandom;
      if (i < DEPTH) sent[i] = d;
      cyc(1, d, 0, '0, 0);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL ovf_fill: got %h expected %h", obs, exp); end
      if (i == DEPTH - 1) begin
        n_chk++;
        if (in_ready !== 1'b0 || level !== 5'd16) begin
          n_fail++; $display("FAIL ovf_full: in_ready %b level %0d, need 0 16", in_ready, level);
        end
      end
    end
    n_chk++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      n_fail++; $display("FAIL ovf_flag: overflow %b level %0d, need 1 16", overflow, level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, '0, 0, '0, 1);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL ovf_drain: got %h expected %h", obs, exp); end
      n_chk++;
      if (obs.out_data !== sent[i]) begin
        n_fail++; $display("FAIL ovf_data: got %h expected %h", obs.out_data, sent[i]);
      end
    end
    n_chk++;
    if (level !== 5'd0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after: level %0d overflow %b, need 0 1", level, overflow);
    end
  endtask

  task automatic test_steady();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, $urandom, 0, '0, 0);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL steady_fill: got %h expected %h", obs, exp); end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1, $urandom, (i == 19), 4'd7, 1);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL steady_flow: got %h expected %h", obs, exp); end
      n_chk++;
      if (level !== 5'd8) begin n_fail++; $display("FAIL steady_level: got %0d expected 8", level); end
    end
    for (int i = 0; i < 9; i++) begin
      cyc(0, '0, 0, '0, 1);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL steady_drain: got %h expected %h", obs, exp); end
    end
    n_chk++;
    if (overflow !== 1'b0 || frame_words !== 8'd28 || busy !== 1'b0) begin
      n_fail++; $display("FAIL steady_end: overflow %b words %0d busy %b, need 0 28 0",
                         overflow, frame_words, busy);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, $urandom, (i == 1 || i == 5), (i < 2) ? 4'd1 : 4'd5, (i % 2 == 0));
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL b2b_push: got %h expected %h", obs, exp); end
      if (obs.frame_done === 1'b1) pulses++;
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, '0, 0, '0, (i % 2 == 0));
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL b2b_drain: got %h expected %h", obs, exp); end
      if (obs.frame_done === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 2 || frame_count !== 8'd2 || frame_words !== 8'd4 ||
        frame_moves !== 4'd5 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_stats: pulses %0d count %0d words %0d moves %0d busy %b, need 2 2 4 5 0",
                         pulses, frame_count, frame_words, frame_moves, busy);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, $urandom, 0, '0, 0);
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL mid_push: got %h expected %h", obs, exp); end
    end
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    n_chk++;
    if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        frame_count !== 8'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: valid %b level %0d ready %b busy %b count %0d ovf %b, need 0 0 1 0 0 0",
                         out_valid, level, in_ready, busy, frame_count, overflow);
    end
    cyc(1, 32'hCAFE_0001, 1, 4'd2, 0);
    cyc(0, '0, 0, '0, 1);
    n_chk++;
    if (obs !== exp) begin n_fail++; $display("FAIL mid_pop: got %h expected %h", obs, exp); end
    cyc(0, '0, 0, '0, 1);
    n_chk++;
    if (frame_words !== 8'd1 || frame_count !== 8'd1 || frame_moves !== 4'd2) begin
      n_fail++; $display("FAIL mid_frame: words %0d count %0d moves %0d, need 1 1 2",
                         frame_words, frame_count, frame_moves);
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 0, '0, 1);
      n_chk++;
      if (obs.frame_done !== 1'b0 || obs.level !== 5'd0 || obs.out_valid !== 1'b0 || level !== 5'd0) begin
        n_fail++; $display("FAIL empty_pop: frame_done %b level %0d valid %b, need 0 0 0",
                           obs.frame_done, obs.level, obs.out_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0),
          CNT_W'($urandom), ($urandom_range(0, 1) == 1));
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL random_cycle %0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0; in_move_count = '0; out_ready = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_steady();
    test_back_to_back();
    test_reset_midframe();
    test_empty_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
